// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
package key_cond_pkg;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    DEB_DOWN = 2'd1,
    DOWN     = 2'd2,
    DEB_UP   = 2'd3
  } key_state_t;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce FSM with saturating counter,
// registered level and press/release pulses; hold counter only with KEY_AUTOREPEAT_EN.
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw_n,
  output logic o_level_n,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The sample taken in UP/DOWN is the first stable cycle, so a
  // one-cycle debounce accepts straight from the stable state.
  localparam bit FAST_ACCEPT = (DEBOUNCE_CYCLES == 1);

  logic [1:0]       r_sync;
  logic             w_s;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             r_level_n;
  logic             r_press;
  logic             r_release;
  logic             w_rep_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_key_raw_n};
    end
  end

  assign w_s       = r_sync[1];
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_accept  = (w_cnt_inc >= ACCEPT_AT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= UP;
      r_cnt     <= '0;
      r_level_n <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        UP: begin
          if (!w_s) begin
            if (FAST_ACCEPT) begin
              r_state   <= DOWN;
              r_level_n <= 1'b0;
              r_press   <= 1'b1;
            end else begin
              r_cnt   <= '0;
              r_state <= DEB_DOWN;
            end
          end
        end
        DEB_DOWN: begin
          if (w_s) begin
            r_state <= UP;
          end else if (w_accept) begin
            r_state   <= DOWN;
            r_level_n <= 1'b0;
            r_press   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DOWN: begin
          if (w_s) begin
            if (FAST_ACCEPT) begin
              r_state   <= UP;
              r_level_n <= 1'b1;
              r_release <= 1'b1;
            end else begin
              r_cnt   <= '0;
              r_state <= DEB_UP;
            end
          end else begin
            r_press <= w_rep_fire;
          end
        end
        DEB_UP: begin
          if (!w_s) begin
            r_state <= DOWN;
          end else if (w_accept) begin
            r_state   <= UP;
            r_level_n <= 1'b1;
            r_release <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= UP;
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] FIRST_AT = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] NEXT_AT  = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_repeating;
  logic              w_holding;

  // r_hold equals the number of cycles spent in DOWN since the last pulse
  assign w_holding  = (r_state == DOWN) && !w_s;
  assign w_rep_fire = w_holding && (r_hold == (r_repeating ? NEXT_AT : FIRST_AT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_repeating <= 1'b0;
    end else if (!w_holding) begin
      r_hold      <= '0;
      r_repeating <= 1'b0;
    end else if (w_rep_fire) begin
      r_hold      <= '0;
      r_repeating <= 1'b1;
    end else begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign o_level_n = r_level_n;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button conditioner: N_KEYS independent debounced channels.
// Define KEY_AUTOREPEAT_EN to add held-key auto-repeat press pulses.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_raw_n,
  output logic [N_KEYS-1:0] key_level_n,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_key_raw_n (key_raw_n[gi]),
        .o_level_n   (key_level_n[gi]),
        .o_press     (key_press[gi]),
        .o_release   (key_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Auto-repeat expectations follow KEY_AUTOREPEAT_EN.
module tb_key_conditioner;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [1:0] key_raw_n = 2'b11;
  logic [1:0] key_level_n;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int checks = 0;
  int errors = 0;

  always #5 clk_clk = ~clk_clk;

  key_conditioner #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (4)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
`endif
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_raw_n     (key_raw_n),
    .key_level_n   (key_level_n),
    .key_press     (key_press),
    .key_release   (key_release)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_l, exp_p, exp_r;
    key_raw_n = 2'b00;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if ({key_level_n, key_press, key_release} !== {2'b11, 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL reset_hold t=%0d: level=%b press=%b release=%b, expected 11/00/00",
                 t, key_level_n, key_press, key_release);
      end
    end
    reset_reset_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b00 : 2'b11;
      exp_p = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL reset_release_press t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b11 : 2'b00;
      exp_r = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, 2'b00, exp_r}) begin
        errors++;
        $display("FAIL reset_release_release t=%0d: level=%b press=%b release=%b, expected %b/00/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_l, exp_p, exp_r;
    key_raw_n = 2'b01;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b01 : 2'b11;
      exp_p = (t == 6) ? 2'b10 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL clean_press t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b11 : 2'b01;
      exp_r = (t == 6) ? 2'b10 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, 2'b00, exp_r}) begin
        errors++;
        $display("FAIL clean_release t=%0d: level=%b press=%b release=%b, expected %b/00/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_l, exp_p, exp_r;
    // 2-cycle bounces never reach 4 stable synchronized samples
    for (int i = 0; i < 10; i++) begin
      key_raw_n[0] = ~key_raw_n[0];
      for (int t = 1; t <= 2; t++) begin
        tick();
        checks++;
        if ({key_level_n, key_press, key_release} !== {2'b11, 2'b00, 2'b00}) begin
          errors++;
          $display("FAIL bounce_quiet i=%0d: level=%b press=%b release=%b, expected 11/00/00",
                   i, key_level_n, key_press, key_release);
        end
      end
    end
    key_raw_n = 2'b10;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b10 : 2'b11;
      exp_p = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL bounce_press t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b11 : 2'b10;
      exp_r = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, 2'b00, exp_r}) begin
        errors++;
        $display("FAIL bounce_release t=%0d: level=%b press=%b release=%b, expected %b/00/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_l, exp_p, exp_r;
    key_raw_n = 2'b00;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b00 : 2'b11;
      exp_p = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL simul_press t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b11 : 2'b00;
      exp_r = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, 2'b00, exp_r}) begin
        errors++;
        $display("FAIL simul_release t=%0d: level=%b press=%b release=%b, expected %b/00/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_r);
      end
    end
    // key 0 falls one cycle before key 1; t counts from key 0's edge
    key_raw_n = 2'b10;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_l = {(t < 7) ? 1'b1 : 1'b0, (t < 6) ? 1'b1 : 1'b0};
      exp_p = (t == 6) ? 2'b01 : ((t == 7) ? 2'b10 : 2'b00);
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL stagger_press t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
      if (t == 1) key_raw_n = 2'b00;
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_r = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if (key_release !== exp_r) begin
        errors++;
        $display("FAIL stagger_release t=%0d: release=%b, expected %b", t, key_release, exp_r);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp_l, exp_p, exp_r;
    key_raw_n = 2'b10;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if ({key_level_n, key_press, key_release} !== {2'b11, 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL midrst_pre t=%0d: level=%b press=%b release=%b, expected 11/00/00",
                 t, key_level_n, key_press, key_release);
      end
    end
    reset_reset_n = 1'b0;
    #1;
    for (int t = 0; t <= 3; t++) begin
      if (t > 0) tick();
      checks++;
      if ({key_level_n, key_press, key_release} !== {2'b11, 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL midrst_in_reset t=%0d: level=%b press=%b release=%b, expected 11/00/00",
                 t, key_level_n, key_press, key_release);
      end
    end
    reset_reset_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b10 : 2'b11;
      exp_p = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, 2'b00}) begin
        errors++;
        $display("FAIL midrst_repress t=%0d: level=%b press=%b release=%b, expected %b/%b/00",
                 t, key_level_n, key_press, key_release, exp_l, exp_p);
      end
    end
    key_raw_n = 2'b11;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_l = (t >= 6) ? 2'b11 : 2'b10;
      exp_r = (t == 6) ? 2'b01 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, 2'b00, exp_r}) begin
        errors++;
        $display("FAIL midrst_release t=%0d: level=%b press=%b release=%b, expected %b/00/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic [1:0] exp_l, exp_p, exp_r;
    bit rep_en;
`ifdef KEY_AUTOREPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    // Key 0 low for ticks 1..30; accepted at 6, repeats at 16,19,...
    // The FSM still sees the key held until tick 32 (synchronizer delay),
    // so the last repeat is at 31; release accepted at 36.
    key_raw_n = 2'b10;
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp_p = 2'b00;
      if (t == 6) exp_p = 2'b01;
      if (rep_en && t >= 16 && t <= 32 && ((t - 16) % 3) == 0) exp_p = 2'b01;
      exp_l = (t >= 6 && t < 36) ? 2'b10 : 2'b11;
      exp_r = (t == 36) ? 2'b01 : 2'b00;
      checks++;
      if ({key_level_n, key_press, key_release} !== {exp_l, exp_p, exp_r}) begin
        errors++;
        $display("FAIL autorepeat t=%0d: level=%b press=%b release=%b, expected %b/%b/%b",
                 t, key_level_n, key_press, key_release, exp_l, exp_p, exp_r);
      end
      if (t == 30) key_raw_n = 2'b11;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
